fod_phase_cali: RTL and testbench

Closed-loop phase-synchronisation calibrator for the FOD output path. It sits directly downstream of the PHE sampler (the FAUX4G level captured on each FDTC_SYNC rising edge) and upstream of the DCDL, whose delay code is its output. Each valid PHE sample is a ±1 bang-bang phase error. The block decimates these samples and runs a sign-LMS accumulator with programmable gain. It drives the DCDL code so that FDTC_SYNC edges align to the FAUX4G falling edge, and it reports lock.

---
 rtl/fod_pkg.sv | 31 +++
 rtl/fod_phe_decim.sv | 50 +++++
 rtl/fod_phase_cali.sv | 163 ++++++++++++++++
 tb/tb_fod_phase_cali.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fod_pkg.sv
// fod_pkg: shared types and constants for the FOD phase-synchronisation calibrator.
//   fod_state_t    : loop state (IDLE, ACQ, LOCKED)
//   LOCK_ALT_N     : alternating/zero dumps needed to declare lock
//   UNLOCK_SAME_N  : consecutive same-sign dumps that break lock
//   KS_MAX         : ceiling applied to the programmed gain shift
//   LOCK_GAIN_DROP : gain-shift reduction while locked
//   fod_gain()     : effective accumulator shift for a given KS and lock state
package fod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } fod_state_t;

    localparam int LOCK_ALT_N     = 8;
    localparam int UNLOCK_SAME_N  = 16;
    localparam int KS_MAX         = 16;
    localparam int LOCK_GAIN_DROP = 2;

    // Clamp KS to KS_MAX; while locked back the gain off, never below zero.
    function automatic logic [4:0] fod_gain(input logic [4:0] ks, input logic locked);
        logic [4:0] k;
        k = (ks > 5'(KS_MAX)) ? 5'(KS_MAX) : ks;
        if (locked) begin
            k = (k > 5'(LOCK_GAIN_DROP)) ? (k - 5'(LOCK_GAIN_DROP)) : 5'd0;
        end
        return k;
    endfunction

endpackage

// File: rtl/fod_phe_decim.sv
// fod_phe_decim: decimator for bang-bang PHE samples.
// Each valid sample contributes e = PHE ? -1 : +1 to a signed 9-bit running sum.
// Every 2^F valid samples the window closes: o_dump pulses for that cycle and
// o_dsum carries the window total including the current sample.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clr          : hold sum and counter at zero (loop idle or disabled)
//   i_valid        : PHE sample is fresh and the loop is running
//   i_phe          : phase error, 1 = late, 0 = early
//   i_freqdown     : decimation exponent F
//   o_dsum         : window total, meaningful when o_dump is high
//   o_dump         : window-close strobe (combinational)
module fod_phe_decim (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic              i_phe,
    input  logic [2:0]        i_freqdown,
    output logic signed [8:0] o_dsum,
    output logic              o_dump
);

    logic signed [8:0] r_sum;
    logic [6:0]        r_cnt;
    logic [6:0]        w_last;
    logic signed [8:0] w_e;

    assign w_last = 7'((8'd1 << i_freqdown) - 8'd1);
    assign w_e    = i_phe ? -9'sd1 : 9'sd1;

    // >= rather than == so that shrinking F mid-window dumps on the next sample
    assign o_dump = i_valid && (r_cnt >= w_last);
    assign o_dsum = r_sum + w_e;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            if (o_dump) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else begin
                r_sum <= r_sum + w_e;
                r_cnt <= r_cnt + 7'd1;
            end
        end
    end

endmodule

// File: rtl/fod_phase_cali.sv
// fod_phase_cali: closed-loop sign-LMS phase calibrator driving the DCDL code.
// Decimated PHE dumps are shifted by a programmable gain and accumulated with
// saturation; the top W_CODE bits plus a static offset form the DCDL code.
// A small FSM declares lock after a run of alternating/zero dumps and drops it
// after a run of same-sign dumps.
//   CLK, RST    : clock, synchronous active-high reset
//   EN          : calibration enable
//   PHE_VALID   : fresh PHE sample this cycle
//   PHE         : phase error, 1 = FDTC_SYNC late, 0 = early
//   FREQDOWN    : decimation exponent F (one dump per 2^F samples)
//   KS          : gain shift, clamped to 16
//   PHASE_CTRL  : static offset added to the code (wraps)
//   PHASE_C     : registered DCDL code
//   LOCK        : registered lock flag
//   ACC         : accumulator readback
module fod_phase_cali
    import fod_pkg::*;
#(
    parameter int W_CODE = 10,
    parameter int W_ACC  = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              PHE_VALID,
    input  logic              PHE,
    input  logic [2:0]        FREQDOWN,
    input  logic [4:0]        KS,
    input  logic [W_CODE-1:0] PHASE_CTRL,
    output logic [W_CODE-1:0] PHASE_C,
    output logic              LOCK,
    output logic [W_ACC-1:0]  ACC
);

    localparam int W_EXT = W_ACC + 9;
    localparam logic [W_ACC-1:0]         ACC_MID = {1'b1, {(W_ACC-1){1'b0}}};
    localparam logic [W_CODE-1:0]        PC_MID  = {1'b1, {(W_CODE-1){1'b0}}};
    localparam logic signed [W_EXT-1:0]  ACC_MAX = {{9{1'b0}}, {W_ACC{1'b1}}};

    // Clamp the wide update to the unsigned accumulator range instead of wrapping.
    function automatic logic [W_ACC-1:0] sat_acc(input logic signed [W_EXT-1:0] v);
        if (v[W_EXT-1]) begin
            return '0;
        end else if (v > ACC_MAX) begin
            return '1;
        end else begin
            return v[W_ACC-1:0];
        end
    endfunction

    fod_state_t         r_state, w_state_nxt;
    logic [3:0]         r_alt, w_alt_nxt;
    logic [4:0]         r_same, w_same_nxt;
    logic               r_prevneg, w_prevneg_nxt;
    logic [W_ACC-1:0]   r_acc, w_acc_nxt;
    logic [W_CODE-1:0]  r_phase_c;
    logic               r_lock;

    logic               w_clr;
    logic               w_valid;
    logic signed [8:0]  w_dsum;
    logic               w_dump;
    logic [4:0]         w_gain;
    logic signed [W_EXT-1:0] w_dsum_ext;
    logic signed [W_EXT-1:0] w_step;
    logic signed [W_EXT-1:0] w_acc_sum;

    // Stage 0: decimation of raw PHE samples
    assign w_clr   = !EN || (r_state == IDLE);
    assign w_valid = PHE_VALID && EN && (r_state != IDLE);

    fod_phe_decim u_decim (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_clr      (w_clr),
        .i_valid    (w_valid),
        .i_phe      (PHE),
        .i_freqdown (FREQDOWN),
        .o_dsum     (w_dsum),
        .o_dump     (w_dump)
    );

    // Stage 1: gain, saturating accumulate and lock tracking at each dump
    assign w_gain     = fod_gain(KS, r_state == LOCKED);
    assign w_dsum_ext = {{W_ACC{w_dsum[8]}}, w_dsum};
    assign w_step     = w_dsum_ext <<< w_gain;
    assign w_acc_sum  = $signed({9'b0, r_acc}) + w_step;

    always_comb begin
        w_state_nxt   = r_state;
        w_alt_nxt     = r_alt;
        w_same_nxt    = r_same;
        w_prevneg_nxt = r_prevneg;
        w_acc_nxt     = r_acc;
        if (!EN) begin
            w_state_nxt = IDLE;
            w_alt_nxt   = '0;
            w_same_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ACQ;
                    w_alt_nxt   = '0;
                    w_same_nxt  = '0;
                end
                ACQ, LOCKED: begin
                    if (w_dump) begin
                        w_acc_nxt = sat_acc(w_acc_sum);
                        // A zero dump counts as alternating: the loop is dithering.
                        if ((w_dsum == 9'sd0) || (w_dsum[8] != r_prevneg)) begin
                            w_alt_nxt  = (r_alt == 4'(LOCK_ALT_N)) ? r_alt : r_alt + 4'd1;
                            w_same_nxt = '0;
                        end else begin
                            w_same_nxt = (r_same == 5'(UNLOCK_SAME_N)) ? r_same : r_same + 5'd1;
                            w_alt_nxt  = '0;
                        end
                        if (w_dsum != 9'sd0) begin
                            w_prevneg_nxt = w_dsum[8];
                        end
                        if ((r_state == ACQ) && (w_alt_nxt == 4'(LOCK_ALT_N))) begin
                            w_state_nxt = LOCKED;
                            w_alt_nxt   = '0;
                        end else if ((r_state == LOCKED) && (w_same_nxt == 5'(UNLOCK_SAME_N))) begin
                            w_state_nxt = ACQ;
                            w_same_nxt  = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_alt_nxt   = '0;
                    w_same_nxt  = '0;
                end
            endcase
        end
    end

    // Stage 2: registered state, accumulator and outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_alt     <= '0;
            r_same    <= '0;
            r_prevneg <= 1'b0;
            r_acc     <= ACC_MID;
            r_phase_c <= PC_MID;
            r_lock    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_alt     <= w_alt_nxt;
            r_same    <= w_same_nxt;
            r_prevneg <= w_prevneg_nxt;
            r_acc     <= w_acc_nxt;
            r_phase_c <= r_acc[W_ACC-1 -: W_CODE] + PHASE_CTRL;
            r_lock    <= (w_state_nxt == LOCKED);
        end
    end

    assign PHASE_C = r_phase_c;
    assign LOCK    = r_lock;
    assign ACC     = r_acc;

endmodule

// File: tb/tb_fod_phase_cali.sv
// tb_fod_phase_cali: self-checking bench for fod_phase_cali.
// A behavioural model steps once per clock from the driven inputs and pushes
// the expected {ACC, PHASE_C, LOCK} into a scoreboard queue; after the edge the
// entry is popped and compared against the DUT. Directed checks cover the
// specific values called out for each scenario.
module tb_fod_phase_cali;

    localparam int W_CODE = 10;
    localparam int W_ACC  = 24;

    logic              CLK;
    logic              RST;
    logic              EN;
    logic              PHE_VALID;
    logic              PHE;
    logic [2:0]        FREQDOWN;
    logic [4:0]        KS;
    logic [W_CODE-1:0] PHASE_CTRL;
    logic [W_CODE-1:0] PHASE_C;
    logic              LOCK;
    logic [W_ACC-1:0]  ACC;

    fod_phase_cali #(.W_CODE(W_CODE), .W_ACC(W_ACC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .PHE_VALID  (PHE_VALID),
        .PHE        (PHE),
        .FREQDOWN   (FREQDOWN),
        .KS         (KS),
        .PHASE_CTRL (PHASE_CTRL),
        .PHASE_C    (PHASE_C),
        .LOCK       (LOCK),
        .ACC        (ACC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W_ACC-1:0]  acc;
        logic [W_CODE-1:0] pc;
        logic              lock;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // model state: 0 = IDLE, 1 = ACQ, 2 = LOCKED
    int     m_state   = 0;
    int     m_sum     = 0;
    int     m_cnt     = 0;
    int     m_alt     = 0;
    int     m_same    = 0;
    bit     m_prevneg = 1'b0;
    longint m_acc     = 64'h800000;
    int     m_pc      = 512;
    bit     m_lock    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int     e;
        int     dsum;
        int     ksc;
        int     g;
        longint nxt;
        exp_t   x;
        if (RST) begin
            m_state = 0; m_sum = 0; m_cnt = 0; m_alt = 0; m_same = 0;
            m_prevneg = 1'b0; m_acc = 64'h800000; m_pc = 512;
        end else begin
            m_pc = int'(((m_acc >> (W_ACC - W_CODE)) + longint'(PHASE_CTRL)) % 1024);
            if (!EN) begin
                m_state = 0; m_sum = 0; m_cnt = 0; m_alt = 0; m_same = 0;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (PHE_VALID) begin
                e = PHE ? -1 : 1;
                if (m_cnt + 1 >= (1 << FREQDOWN)) begin
                    dsum  = m_sum + e;
                    m_sum = 0;
                    m_cnt = 0;
                    ksc = (int'(KS) > 16) ? 16 : int'(KS);
                    g   = (m_state == 2) ? ((ksc >= 2) ? ksc - 2 : 0) : ksc;
                    nxt = m_acc + longint'(dsum) * (longint'(1) << g);
                    if (nxt < 0) nxt = 0;
                    if (nxt > 64'hFFFFFF) nxt = 64'hFFFFFF;
                    m_acc = nxt;
                    if (dsum == 0 || ((dsum < 0) != m_prevneg)) begin
                        m_alt++; m_same = 0;
                    end else begin
                        m_same++; m_alt = 0;
                    end
                    if (dsum != 0) m_prevneg = (dsum < 0);
                    if (m_state == 1 && m_alt >= 8) begin
                        m_state = 2; m_alt = 0;
                    end else if (m_state == 2 && m_same >= 16) begin
                        m_state = 1; m_same = 0;
                    end
                end else begin
                    m_sum += e;
                    m_cnt++;
                end
            end
        end
        m_lock = (m_state == 2);
        x.acc  = m_acc[W_ACC-1:0];
        x.pc   = m_pc[W_CODE-1:0];
        x.lock = m_lock;
        sb_q.push_back(x);
    endtask

    // One clock: model the cycle from the current inputs, then compare after the edge.
    task automatic cyc();
        exp_t x;
        model_step();
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            check("sb_acc",  32'(ACC),     32'(x.acc));
            check("sb_pc",   32'(PHASE_C), 32'(x.pc));
            check("sb_lock", 32'(LOCK),    32'(x.lock));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [W_ACC-1:0] a0;

    initial begin
        RST = 1'b1; EN = 1'b0; PHE_VALID = 1'b0; PHE = 1'b0;
        FREQDOWN = 3'd0; KS = 5'd0; PHASE_CTRL = 10'd0;
        #1;
        run(2);

        // reset values, idle tracking of PHASE_CTRL
        RST = 1'b0; PHASE_CTRL = 10'd5;
        run(3);
        check("idle_acc",  32'(ACC),     32'h800000);
        check("idle_pc",   32'(PHASE_C), 32'd517);
        check("idle_lock", 32'(LOCK),    32'd0);

        // acquisition: PHE late every sample, F=0, KS=8
        PHASE_CTRL = 10'd0; EN = 1'b1; FREQDOWN = 3'd0; KS = 5'd8;
        PHE_VALID = 1'b1; PHE = 1'b1;
        run(5);
        check("acq_acc_4dumps", 32'(ACC), 32'h7FFC00);
        run(1);
        check("acq_pc",   32'(PHASE_C), 32'd511);
        check("acq_lock", 32'(LOCK),    32'd0);

        // alternating PHE with F=3, KS=0: zero dumps drive lock
        FREQDOWN = 3'd3; KS = 5'd0;
        a0 = ACC;
        for (int i = 0; i < 63; i++) begin
            PHE = i[0];
            cyc();
        end
        check("alt_lock_7", 32'(LOCK), 32'd0);
        PHE = 1'b1;
        cyc();
        check("alt_lock_8", 32'(LOCK), 32'd1);
        check("alt_acc_hold", 32'(ACC), 32'(a0));

        // locked: constant early PHE, reduced gain then unlock
        FREQDOWN = 3'd0; KS = 5'd8; PHE = 1'b0;
        a0 = ACC;
        run(1);
        check("lock_step64", 32'(ACC), 32'(a0) + 32'd64);
        run(15);
        check("lock_hold_16", 32'(LOCK), 32'd1);
        run(1);
        check("unlock_17", 32'(LOCK), 32'd0);
        a0 = ACC;
        run(1);
        check("acq_step256", 32'(ACC), 32'(a0) + 32'd256);

        // PHE_VALID low: nothing accumulates
        PHE_VALID = 1'b0;
        a0 = ACC;
        for (int i = 0; i < 6; i++) begin
            PHE = i[0];
            cyc();
        end
        check("novalid_acc", 32'(ACC), 32'(a0));
        PHE_VALID = 1'b1;

        // saturation high then low
        PHASE_CTRL = 10'd7; KS = 5'd16; PHE = 1'b0;
        run(200);
        check("sat_hi_acc",  32'(ACC),     32'hFFFFFF);
        check("sat_hi_pc",   32'(PHASE_C), 32'd6);
        check("sat_hi_lock", 32'(LOCK),    32'd0);
        PHE = 1'b1;
        run(300);
        check("sat_lo_acc", 32'(ACC),     32'd0);
        check("sat_lo_pc",  32'(PHASE_C), 32'd7);

        // reset mid-window
        FREQDOWN = 3'd3; KS = 5'd4; PHE = 1'b0;
        run(5);
        RST = 1'b1;
        run(1);
        check("rst_mid_acc",  32'(ACC),     32'h800000);
        check("rst_mid_pc",   32'(PHASE_C), 32'd512);
        check("rst_mid_lock", 32'(LOCK),    32'd0);
        RST = 1'b0;

        // EN drop mid-window: partial sum discarded
        run(1);
        run(5);
        a0 = ACC;
        EN = 1'b0;
        run(1);
        check("endrop_acc", 32'(ACC), 32'(a0));
        EN = 1'b1;
        run(1);
        run(8);
        check("after_endrop_dump", 32'(ACC), 32'(a0) + 32'd128);

        // F reduced mid-window: counter already past the new limit
        run(5);
        FREQDOWN = 3'd2;
        a0 = ACC;
        run(1);
        check("fchg_dump", 32'(ACC), 32'(a0) + 32'd96);
        a0 = ACC;
        run(4);
        check("fchg_next", 32'(ACC), 32'(a0) + 32'd64);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
